// File: rtl/mirfak_defines.sv
// Shared definitions for the Mirfak fetch stage: FSM encodings and
// instruction constants.
package mirfak_defines;

   typedef enum logic [1:0] {
      FETCH_REQ  = 2'd0,
      FETCH_KILL = 2'd1,
      FETCH_HOLD = 2'd2,
      FETCH_HALT = 2'd3
   } fetch_state_e;

   localparam logic [31:0] NOP       = 32'h0000_0013;
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/mirfak_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs single-outstanding Wishbone reads
// and holds one fetched word for the IF/ID handshake.
module mirfak_fetch_unit #(
   parameter logic [31:0] RESET_ADDR = 32'h8000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic [31:0] iwbm_addr_o,
   output logic        iwbm_cyc_o,
   output logic        iwbm_stb_o,
   input  logic [31:0] iwbm_data_i,
   input  logic        iwbm_ack_i,
   input  logic        iwbm_err_i,
   input  logic        ifid_enable_i,
   input  logic        id_bj_taken_i,
   input  logic [31:0] id_bj_target_i,
   input  logic        wb_exception_i,
   input  logic        wb_xret_i,
   input  logic [31:0] wb_target_i,
   output logic        if_ready_o,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_instruction_o,
   output logic        if_bus_error_o
);
   import mirfak_defines::*;

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  kill_addr_q, kill_addr_d;
   logic         cyc_q, cyc_d;
   logic [31:0]  buf_pc_q, buf_pc_d;
   logic [31:0]  buf_instr_q, buf_instr_d;
   logic         buf_err_q, buf_err_d;

   logic         redirect;
   logic [31:0]  target;
   logic         beat_done;

   assign redirect  = wb_exception_i | wb_xret_i | id_bj_taken_i;
   assign target    = ((wb_exception_i | wb_xret_i) ? wb_target_i : id_bj_target_i) & WORD_MASK;
   // cyc_q gates termination so a stray ack outside a bus cycle is ignored.
   assign beat_done = cyc_q & (iwbm_ack_i | iwbm_err_i);

   always_comb begin
      // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      pc_d        = pc_q;
      kill_addr_d = kill_addr_q;
      buf_pc_d    = buf_pc_q;
      buf_instr_d = buf_instr_q;
      buf_err_d   = buf_err_q;

      case (state_q)
         FETCH_REQ: begin
            if (beat_done) begin
               if (redirect) begin
                  pc_d = target;
               end else begin
                  buf_pc_d    = pc_q;
                  buf_instr_d = iwbm_err_i ? NOP : iwbm_data_i;
                  buf_err_d   = iwbm_err_i;
                  state_d     = FETCH_HOLD;
               end
            end else if (redirect) begin
               pc_d = target;
               // Before the first request is on the bus there is nothing to kill.
               if (cyc_q) begin
                  kill_addr_d = pc_q;
                  state_d     = FETCH_KILL;
               end
            end
         end
         FETCH_KILL: begin
            if (redirect)  pc_d    = target;
            if (beat_done) state_d = FETCH_REQ;
         end
         FETCH_HOLD: begin
            if (redirect) begin
               pc_d    = target;
               state_d = FETCH_REQ;
            end else if (ifid_enable_i) begin
               if (buf_err_q) begin
                  state_d = FETCH_HALT;
               end else begin
                  pc_d    = pc_q + 32'd4;
                  state_d = FETCH_REQ;
               end
            end
         end
         FETCH_HALT: begin
            if (redirect) begin
               pc_d    = target;
               state_d = FETCH_REQ;
            end
         end
         default: state_d = FETCH_REQ;
      endcase

      cyc_d = (state_d == FETCH_REQ) || (state_d == FETCH_KILL);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= FETCH_REQ;
         pc_q        <= RESET_ADDR;
         kill_addr_q <= RESET_ADDR;
         cyc_q       <= 1'b0;
         buf_pc_q    <= RESET_ADDR;
         buf_instr_q <= NOP;
         buf_err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q     <= state_d;
         pc_q        <= pc_d;
         kill_addr_q <= kill_addr_d;
         cyc_q       <= cyc_d;
         buf_pc_q    <= buf_pc_d;
         buf_instr_q <= buf_instr_d;
         buf_err_q   <= buf_err_d;
      end
   end

   // A killed cycle stays at its original address until the slave terminates it.
   assign iwbm_addr_o      = (state_q == FETCH_KILL) ? kill_addr_q : pc_q;
   assign iwbm_cyc_o       = cyc_q;
   assign iwbm_stb_o       = cyc_q;
   assign if_ready_o       = (state_q == FETCH_HOLD);
   assign if_pc_o          = buf_pc_q;
   assign if_instruction_o = if_ready_o ? buf_instr_q : NOP;
   assign if_bus_error_o   = if_ready_o & buf_err_q;

endmodule

// File: tb/tb_mirfak_fetch_unit.sv
// Self-checking bench for mirfak_fetch_unit: directed handshake/redirect scenarios
// plus a randomized run against a PC-sequence reference model.
module tb_mirfak_fetch_unit;

   localparam logic [31:0] RST_A = 32'h8000_0000;
   localparam logic [31:0] NOP_W = 32'h0000_0013;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [31:0] iwbm_addr_o;
   logic        iwbm_cyc_o, iwbm_stb_o;
   logic [31:0] iwbm_data_i = '0;
   logic        iwbm_ack_i = 1'b0, iwbm_err_i = 1'b0;
   logic        ifid_enable_i = 1'b0;
   logic        id_bj_taken_i = 1'b0;
   logic [31:0] id_bj_target_i = '0;
   logic        wb_exception_i = 1'b0, wb_xret_i = 1'b0;
   logic [31:0] wb_target_i = '0;
   logic        if_ready_o;
   logic [31:0] if_pc_o, if_instruction_o;
   logic        if_bus_error_o;

   mirfak_fetch_unit #(.RESET_ADDR(RST_A)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .iwbm_addr_o(iwbm_addr_o), .iwbm_cyc_o(iwbm_cyc_o), .iwbm_stb_o(iwbm_stb_o),
      .iwbm_data_i(iwbm_data_i), .iwbm_ack_i(iwbm_ack_i), .iwbm_err_i(iwbm_err_i),
      .ifid_enable_i(ifid_enable_i), .id_bj_taken_i(id_bj_taken_i),
      .id_bj_target_i(id_bj_target_i), .wb_exception_i(wb_exception_i),
      .wb_xret_i(wb_xret_i), .wb_target_i(wb_target_i),
      .if_ready_o(if_ready_o), .if_pc_o(if_pc_o),
      .if_instruction_o(if_instruction_o), .if_bus_error_o(if_bus_error_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_bad = 0;

   // Memory slave state
   int          fixed_wait = 0;   // <0 selects random 0..3 wait states
   bit          err_en = 1'b0;
   bit          force_err = 1'b0;
   bit          busy = 1'b0;
   int          cnt = 0;
   bit          new_start = 1'b0;
   logic [31:0] start_addr = '0;
   int          cycle = 0;
   logic [31:0] starts[$];
   int          start_cyc[$];

   function automatic logic [31:0] mem(input logic [31:0] a);
      if (a == 32'h8000_0000) return 32'h0000_0093;
      return {a[31:2] ^ 30'h2AAA_5555, 2'b11};
   endfunction

   function automatic bit is_err(input logic [31:0] a);
      return err_en && (a[6:2] == 5'h0B);
   endfunction

   // Wishbone slave: drives ack/err on the falling edge for the next rising edge.
   always @(negedge clk_i) begin
      cycle++;
      new_start  = 1'b0;
      iwbm_ack_i = 1'b0;
      iwbm_err_i = 1'b0;
      if (!rst_ni) begin
         busy = 1'b0;
      end else if (iwbm_cyc_o) begin
         n_cmp++;
         if (iwbm_stb_o !== 1'b1) begin
            n_bad++;
            $display("FAIL stb_eq_cyc: stb=%b required 1", iwbm_stb_o);
         end
         if (!busy) begin
            busy       = 1'b1;
            cnt        = (fixed_wait < 0) ? int'($urandom_range(0, 3)) : fixed_wait;
            start_addr = iwbm_addr_o;
            new_start  = 1'b1;
            starts.push_back(iwbm_addr_o);
            start_cyc.push_back(cycle);
         end else begin
            n_cmp++;
            if (iwbm_addr_o !== start_addr) begin
               n_bad++;
               $display("FAIL addr_stable: addr=%h required %h", iwbm_addr_o, start_addr);
            end
         end
         if (cnt == 0) begin
            if (force_err || is_err(start_addr)) begin
               iwbm_err_i = 1'b1;
               force_err  = 1'b0;
            end else begin
               iwbm_ack_i = 1'b1;
            end
            iwbm_data_i = mem(start_addr);
            busy = 1'b0;
         end else begin
            cnt--;
         end
      end else begin
         busy = 1'b0;
      end
   end

   task automatic tick();
      @(negedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      ifid_enable_i  = 1'b0;
      id_bj_taken_i  = 1'b0;
      wb_exception_i = 1'b0;
      wb_xret_i      = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      err_en    = 1'b0;
      force_err = 1'b0;
      rst_ni    = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
      starts.delete();
      start_cyc.delete();
   endtask

   task automatic wait_ready(input string tag);
      int b;
      b = 0;
      while (!if_ready_o && b < 50) begin
         tick();
         b++;
      end
      if (!if_ready_o) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: if_ready_o=0 after 50 cycles, required 1", tag);
      end
   endtask

   task automatic wait_starts(input int n, input string tag);
      int b;
      b = 0;
      while (starts.size() < n && b < 50) begin
         tick();
         b++;
      end
      if (starts.size() < n) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: %0d bus cycles started, required %0d", tag, starts.size(), n);
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_ni = 1'b0;
      tick();
      n_cmp++; if (iwbm_cyc_o !== 1'b0) begin n_bad++; $display("FAIL rst_cyc: %b required 0", iwbm_cyc_o); end
      n_cmp++; if (iwbm_stb_o !== 1'b0) begin n_bad++; $display("FAIL rst_stb: %b required 0", iwbm_stb_o); end
      n_cmp++; if (iwbm_addr_o !== RST_A) begin n_bad++; $display("FAIL rst_addr: %h required %h", iwbm_addr_o, RST_A); end
      n_cmp++; if (if_ready_o !== 1'b0) begin n_bad++; $display("FAIL rst_ready: %b required 0", if_ready_o); end
      n_cmp++; if (if_bus_error_o !== 1'b0) begin n_bad++; $display("FAIL rst_berr: %b required 0", if_bus_error_o); end
      n_cmp++; if (if_pc_o !== RST_A) begin n_bad++; $display("FAIL rst_pc: %h required %h", if_pc_o, RST_A); end
      n_cmp++; if (if_instruction_o !== NOP_W) begin n_bad++; $display("FAIL rst_instr: %h required %h", if_instruction_o, NOP_W); end
   endtask

   task automatic test_first_fetch();
      int waits, b;
      do_reset();
      fixed_wait = 2;
      waits = 0;
      b = 0;
      while (!iwbm_ack_i && b < 20) begin
         tick();
         b++;
         if (iwbm_cyc_o && !iwbm_ack_i) waits++;
         n_cmp++;
         if (if_ready_o !== 1'b0) begin n_bad++; $display("FAIL ff_early_ready: %b required 0", if_ready_o); end
      end
      n_cmp++; if (waits !== 2) begin n_bad++; $display("FAIL ff_waits: %0d required 2", waits); end
      n_cmp++; if (starts.size() < 1 || starts[0] !== RST_A) begin n_bad++; $display("FAIL ff_addr: %0d starts, required first at %h", starts.size(), RST_A); end
      tick();
      n_cmp++; if (if_ready_o !== 1'b1) begin n_bad++; $display("FAIL ff_ready: %b required 1", if_ready_o); end
      n_cmp++; if (if_pc_o !== RST_A) begin n_bad++; $display("FAIL ff_pc: %h required %h", if_pc_o, RST_A); end
      n_cmp++; if (if_instruction_o !== 32'h0000_0093) begin n_bad++; $display("FAIL ff_instr: %h required 00000093", if_instruction_o); end
      tick();
      n_cmp++; if (if_ready_o !== 1'b1 || if_pc_o !== RST_A || if_instruction_o !== 32'h0000_0093) begin
         n_bad++; $display("FAIL ff_hold_stable: ready=%b pc=%h instr=%h", if_ready_o, if_pc_o, if_instruction_o); end
      n_cmp++; if (iwbm_cyc_o !== 1'b0) begin n_bad++; $display("FAIL ff_hold_cyc: %b required 0", iwbm_cyc_o); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] got[$];
      do_reset();
      fixed_wait = 0;
      ifid_enable_i = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (if_ready_o) begin
            got.push_back(if_pc_o);
            n_cmp++;
            if (if_instruction_o !== mem(if_pc_o)) begin n_bad++; $display("FAIL b2b_instr: %h required %h", if_instruction_o, mem(if_pc_o)); end
         end
      end
      ifid_enable_i = 1'b0;
      n_cmp++; if (starts.size() < 3 || got.size() < 3) begin n_bad++; $display("FAIL b2b_count: starts=%0d words=%0d required >=3", starts.size(), got.size()); end
      for (int i = 0; i < 3 && i < starts.size() && i < got.size(); i++) begin
         n_cmp++; if (starts[i] !== RST_A + 32'(4 * i)) begin n_bad++; $display("FAIL b2b_addr%0d: %h required %h", i, starts[i], RST_A + 32'(4 * i)); end
         n_cmp++; if (got[i] !== RST_A + 32'(4 * i)) begin n_bad++; $display("FAIL b2b_word%0d: %h required %h", i, got[i], RST_A + 32'(4 * i)); end
         if (i > 0) begin
            n_cmp++; if (start_cyc[i] - start_cyc[i-1] !== 2) begin n_bad++; $display("FAIL b2b_rate%0d: gap %0d required 2", i, start_cyc[i] - start_cyc[i-1]); end
         end
      end
   endtask

   task automatic test_bj_kill();
      int b;
      do_reset();
      fixed_wait = 3;
      wait_starts(1, "kill_first");
      id_bj_taken_i  = 1'b1;
      id_bj_target_i = 32'h8000_0102;
      tick();
      id_bj_taken_i = 1'b0;
      b = 0;
      while (starts.size() < 2 && b < 20) begin
         n_cmp++;
         if (if_ready_o !== 1'b0) begin n_bad++; $display("FAIL kill_ready: %b required 0 (pc=%h)", if_ready_o, if_pc_o); end
         tick();
         b++;
      end
      n_cmp++; if (starts.size() < 2 || starts[1] !== 32'h8000_0100) begin n_bad++; $display("FAIL kill_next_addr: %0d starts, required 2nd at 80000100", starts.size()); end
      wait_ready("kill");
      n_cmp++; if (if_pc_o !== 32'h8000_0100) begin n_bad++; $display("FAIL kill_pc: %h required 80000100", if_pc_o); end
   endtask

   task automatic test_hold_exception();
      do_reset();
      fixed_wait = 0;
      wait_ready("hx");
      ifid_enable_i  = 1'b1;
      wb_exception_i = 1'b1;
      wb_target_i    = 32'h8000_0040;
      tick();
      clear_inputs();
      n_cmp++; if (if_ready_o !== 1'b0) begin n_bad++; $display("FAIL hx_ready: %b required 0", if_ready_o); end
      n_cmp++; if (iwbm_cyc_o !== 1'b1 || iwbm_addr_o !== 32'h8000_0040) begin n_bad++; $display("FAIL hx_addr: cyc=%b addr=%h required 1/80000040", iwbm_cyc_o, iwbm_addr_o); end
      wait_ready("hx2");
      n_cmp++; if (if_pc_o !== 32'h8000_0040) begin n_bad++; $display("FAIL hx_pc: %h required 80000040", if_pc_o); end
   endtask

   task automatic test_bus_error();
      do_reset();
      fixed_wait = 1;
      force_err  = 1'b1;
      wait_ready("berr");
      n_cmp++; if (if_bus_error_o !== 1'b1) begin n_bad++; $display("FAIL berr_flag: %b required 1", if_bus_error_o); end
      n_cmp++; if (if_instruction_o !== NOP_W) begin n_bad++; $display("FAIL berr_instr: %h required %h", if_instruction_o, NOP_W); end
      ifid_enable_i = 1'b1;
      tick();
      ifid_enable_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (iwbm_cyc_o !== 1'b0 || if_ready_o !== 1'b0) begin n_bad++; $display("FAIL berr_halt%0d: cyc=%b ready=%b required 0/0", i, iwbm_cyc_o, if_ready_o); end
         tick();
      end
      wb_exception_i = 1'b1;
      wb_target_i    = 32'h8000_0200;
      tick();
      clear_inputs();
      n_cmp++; if (iwbm_cyc_o !== 1'b1 || iwbm_addr_o !== 32'h8000_0200) begin n_bad++; $display("FAIL berr_resume: cyc=%b addr=%h required 1/80000200", iwbm_cyc_o, iwbm_addr_o); end
      wait_ready("berr2");
      n_cmp++; if (if_pc_o !== 32'h8000_0200 || if_bus_error_o !== 1'b0) begin n_bad++; $display("FAIL berr_after: pc=%h berr=%b required 80000200/0", if_pc_o, if_bus_error_o); end
   endtask

   task automatic test_wrap_priority();
      do_reset();
      fixed_wait = 0;
      wait_ready("wrap");
      ifid_enable_i  = 1'b1;
      wb_xret_i      = 1'b1;
      wb_target_i    = 32'hFFFF_FFFF;
      id_bj_taken_i  = 1'b1;
      id_bj_target_i = 32'h8000_0500;
      tick();
      clear_inputs();
      n_cmp++; if (iwbm_addr_o !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_target: %h required fffffffc", iwbm_addr_o); end
      wait_ready("wrap2");
      n_cmp++; if (if_pc_o !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_pc: %h required fffffffc", if_pc_o); end
      ifid_enable_i = 1'b1;
      tick();
      ifid_enable_i = 1'b0;
      n_cmp++; if (iwbm_cyc_o !== 1'b1 || iwbm_addr_o !== 32'h0000_0000) begin n_bad++; $display("FAIL wrap_next: cyc=%b addr=%h required 1/00000000", iwbm_cyc_o, iwbm_addr_o); end
   endtask

   task automatic test_reset_mid_req();
      do_reset();
      fixed_wait = 0;
      wait_ready("mr");
      fixed_wait     = 6;
      id_bj_taken_i  = 1'b1;
      id_bj_target_i = 32'h8000_0300;
      tick();
      clear_inputs();
      tick();
      n_cmp++; if (iwbm_cyc_o !== 1'b1 || iwbm_addr_o !== 32'h8000_0300) begin n_bad++; $display("FAIL mr_pre: cyc=%b addr=%h required 1/80000300", iwbm_cyc_o, iwbm_addr_o); end
      rst_ni = 1'b0;
      #1;
      n_cmp++; if (iwbm_cyc_o !== 1'b0 || iwbm_stb_o !== 1'b0) begin n_bad++; $display("FAIL mr_cyc: cyc=%b stb=%b required 0/0", iwbm_cyc_o, iwbm_stb_o); end
      n_cmp++; if (iwbm_addr_o !== RST_A) begin n_bad++; $display("FAIL mr_addr: %h required %h", iwbm_addr_o, RST_A); end
      n_cmp++; if (if_ready_o !== 1'b0 || if_bus_error_o !== 1'b0 || if_pc_o !== RST_A || if_instruction_o !== NOP_W) begin
         n_bad++; $display("FAIL mr_outs: ready=%b berr=%b pc=%h instr=%h", if_ready_o, if_bus_error_o, if_pc_o, if_instruction_o); end
      tick();
      rst_ni = 1'b1;
      fixed_wait = 0;
      starts.delete();
      start_cyc.delete();
      wait_starts(1, "mr_restart");
      n_cmp++; if (starts.size() < 1 || starts[0] !== RST_A) begin n_bad++; $display("FAIL mr_restart: %0d starts, required first at %h", starts.size(), RST_A); end
      wait_ready("mr2");
      n_cmp++; if (if_pc_o !== RST_A || if_instruction_o !== 32'h0000_0093) begin n_bad++; $display("FAIL mr_word: pc=%h instr=%h", if_pc_o, if_instruction_o); end
   endtask

   // Reference model: the next word to appear must be the last redirect target
   // or the previous consumed PC + 4; an errored word halts fetching.
   task automatic test_random();
      logic [31:0] exp_pc, wbt, bjt;
      bit halted, en, exc, xr, bj;
      int delivered;
      do_reset();
      fixed_wait = -1;
      err_en     = 1'b1;
      exp_pc     = RST_A;
      halted     = 1'b0;
      delivered  = 0;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (halted) begin
            n_cmp++;
            if (iwbm_cyc_o !== 1'b0 || if_ready_o !== 1'b0) begin n_bad++; $display("FAIL rnd_halt@%0d: cyc=%b ready=%b required 0/0", i, iwbm_cyc_o, if_ready_o); end
         end
         if (new_start) begin
            n_cmp++;
            if (iwbm_addr_o !== exp_pc) begin n_bad++; $display("FAIL rnd_addr@%0d: %h required %h", i, iwbm_addr_o, exp_pc); end
         end
         if (if_ready_o) begin
            n_cmp++;
            if (if_pc_o !== exp_pc || if_bus_error_o !== is_err(exp_pc) ||
                if_instruction_o !== (is_err(exp_pc) ? NOP_W : mem(exp_pc))) begin
               n_bad++;
               $display("FAIL rnd_word@%0d: pc=%h instr=%h berr=%b required pc=%h instr=%h berr=%b", i,
                        if_pc_o, if_instruction_o, if_bus_error_o, exp_pc,
                        is_err(exp_pc) ? NOP_W : mem(exp_pc), is_err(exp_pc));
            end
         end
         en  = ($urandom % 4) != 0;
         exc = ($urandom % 20) == 0;
         xr  = ($urandom % 25) == 0;
         bj  = ($urandom % 10) == 0;
         wbt = 32'h8000_0000 | ($urandom & 32'h3FF);
         bjt = 32'h8000_0000 | ($urandom & 32'h3FF);
         ifid_enable_i  = en;
         wb_exception_i = exc;
         wb_xret_i      = xr;
         id_bj_taken_i  = bj;
         wb_target_i    = wbt;
         id_bj_target_i = bjt;
         if (exc || xr || bj) begin
            exp_pc = ((exc || xr) ? wbt : bjt) & 32'hFFFF_FFFC;
            halted = 1'b0;
         end else if (if_ready_o && en) begin
            delivered++;
            if (is_err(exp_pc)) halted = 1'b1;
            else exp_pc = exp_pc + 32'd4;
         end
      end
      clear_inputs();
      err_en = 1'b0;
      n_cmp++; if (delivered < 50) begin n_bad++; $display("FAIL rnd_progress: %0d words consumed, required >=50", delivered); end
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_back_to_back();
      test_bj_kill();
      test_hold_exception();
      test_bus_error();
      test_wrap_priority();
      test_reset_mid_req();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
